// File: rtl/cheri_tsmap_arb.sv
// Arbiter for the single-port TSMAP revocation-bitmap SRAM: the revocation pipeline
// always wins, and the bus port uses idle cycles for word reads, writes and atomic set/clear.
module cheri_tsmap_arb #(
  parameter int unsigned TSMapSize = 1024,
  parameter int unsigned AddrW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trvk_cs_i,
  input  logic [AddrW-1:0] trvk_addr_i,
  output logic [31:0]      trvk_rdata_o,
  input  logic             bus_req_i,
  input  logic [1:0]       bus_op_i,
  input  logic [AddrW-1:0] bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic             bus_gnt_o,
  output logic             bus_rvalid_o,
  output logic [31:0]      bus_rdata_o,
  output logic             bus_err_o,
  output logic             sram_req_o,
  output logic             sram_we_o,
  output logic [AddrW-1:0] sram_addr_o,
  output logic [31:0]      sram_wdata_o,
  input  logic [31:0]      sram_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD, RDATA, WR, ERR} state_e;

  localparam logic [AddrW:0] AddrLimit = (AddrW+1)'(TSMapSize);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [31:0]      pend_q, pend_d;
  logic             fwd_q, fwd_d;
  logic             fsm_req, fsm_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      pend_q  <= '0;
      fwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      fwd_q   <= fwd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    // A revocation read of the word about to be written must see the pending value.
    fwd_d        = trvk_cs_i && (state_q == WR) && (trvk_addr_i == addr_q);
    bus_gnt_o    = 1'b0;
    bus_rvalid_o = 1'b0;
    bus_rdata_o  = '0;
    bus_err_o    = 1'b0;
    fsm_req      = 1'b0;
    fsm_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_gnt_o = bus_req_i;
        if (bus_req_i) begin
          op_d   = bus_op_i;
          addr_d = bus_addr_i;
          pend_d = bus_wdata_i;
          if ({1'b0, bus_addr_i} >= AddrLimit) state_d = ERR;
          else if (bus_op_i == 2'b01)          state_d = WR;
          else                                 state_d = RD;
        end
      end
      RD: begin
        if (!trvk_cs_i) begin
          fsm_req = 1'b1;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (op_q == 2'b00) begin
          bus_rvalid_o = 1'b1;
          bus_rdata_o  = sram_rdata_i;
          state_d      = IDLE;
        end else begin
          // pend_q still holds the bit mask captured at grant.
          pend_d  = op_q[0] ? (sram_rdata_i & ~pend_q) : (sram_rdata_i | pend_q);
          state_d = WR;
        end
      end
      WR: begin
        if (!trvk_cs_i) begin
          fsm_req      = 1'b1;
          fsm_we       = 1'b1;
          bus_rvalid_o = 1'b1;
          bus_rdata_o  = pend_q;
          state_d      = IDLE;
        end
      end
      ERR: begin
        bus_rvalid_o = 1'b1;
        bus_err_o    = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_req_o   = trvk_cs_i | fsm_req;
  assign sram_we_o    = fsm_we;
  assign sram_addr_o  = trvk_cs_i ? trvk_addr_i : (fsm_req ? addr_q : '0);
  assign sram_wdata_o = fsm_we ? pend_q : '0;
  assign trvk_rdata_o = fwd_q ? pend_q : sram_rdata_i;

endmodule
